// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm compare, ring/snooze sequencing and alarm time registers
module alarm_ctrl #(
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned MAX_SNOOZES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [5:0] hours_i,
    input  logic [5:0] mins_i,
    input  logic [5:0] secs_i,
    input  logic       set_en,
    input  logic [5:0] set_hours_i,
    input  logic [5:0] set_mins_i,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       stop,
    output logic       ringing,
    output logic [5:0] alarm_hours_o,
    output logic [5:0] alarm_mins_o,
    output logic [1:0] state_o,
    output logic [2:0] snoozes_left_o
);

    localparam logic [9:0] RING_LIMIT   = 10'(RING_SECS);
    localparam logic [9:0] SNOOZE_LIMIT = 10'(SNOOZE_SECS);
    localparam logic [2:0] SNOOZES_INIT = 3'(MAX_SNOOZES);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_RINGING  = 2'b10,
        ST_SNOOZED  = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] ring_cnt_q, ring_cnt_d;
    logic [8:0] snooze_cnt_q, snooze_cnt_d;
    logic [2:0] snoozes_left_q, snoozes_left_d;
    logic [9:0] ring_cnt_inc, snooze_cnt_inc;
    logic       match;
    logic       set_valid;

    // Counters are compared one bit wider so the +1 can never alias back to zero.
    assign ring_cnt_inc   = {1'b0, ring_cnt_q} + 10'd1;
    assign snooze_cnt_inc = {1'b0, snooze_cnt_q} + 10'd1;
    assign match = tick_1hz && (hours_i == alarm_hours_o) && (mins_i == alarm_mins_o)
                   && (secs_i == 6'd0);
    assign set_valid = set_en && (set_hours_i <= 6'd23) && (set_mins_i <= 6'd59);

    always_comb begin
        state_d        = state_q;
        ring_cnt_d     = ring_cnt_q;
        snooze_cnt_d   = snooze_cnt_q;
        snoozes_left_d = snoozes_left_q;
        if (!alarm_en) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (match) begin
                        state_d        = ST_RINGING;
                        ring_cnt_d     = 9'd0;
                        snoozes_left_d = SNOOZES_INIT;
                    end
                end
                ST_RINGING: begin
                    if (stop) begin
                        state_d        = ST_ARMED;
                        snoozes_left_d = 3'd0;
                    end else if (snooze && (snoozes_left_q != 3'd0)) begin
                        state_d        = ST_SNOOZED;
                        snoozes_left_d = snoozes_left_q - 3'd1;
                        snooze_cnt_d   = 9'd0;
                    end else if (tick_1hz) begin
                        if (ring_cnt_inc >= RING_LIMIT) begin
                            state_d        = ST_ARMED;
                            snoozes_left_d = 3'd0;
                        end else begin
                            ring_cnt_d = ring_cnt_inc[8:0];
                        end
                    end
                end
                ST_SNOOZED: begin
                    if (stop) begin
                        state_d        = ST_ARMED;
                        snoozes_left_d = 3'd0;
                    end else if (tick_1hz) begin
                        if (snooze_cnt_inc >= SNOOZE_LIMIT) begin
                            state_d    = ST_RINGING;
                            ring_cnt_d = 9'd0;
                        end else begin
                            snooze_cnt_d = snooze_cnt_inc[8:0];
                        end
                    end
                end
                default: state_d = ST_DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_DISABLED;
            ring_cnt_q     <= 9'd0;
            snooze_cnt_q   <= 9'd0;
            snoozes_left_q <= 3'd0;
            ringing        <= 1'b0;
        end else begin
            state_q        <= state_d;
            ring_cnt_q     <= ring_cnt_d;
            snooze_cnt_q   <= snooze_cnt_d;
            snoozes_left_q <= snoozes_left_d;
            ringing        <= (state_d == ST_RINGING);
        end
    end

    // Alarm time writes are accepted in every state; out-of-range values are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_hours_o <= 6'd0;
            alarm_mins_o  <= 6'd0;
        end else if (set_valid) begin
            alarm_hours_o <= set_hours_i;
            alarm_mins_o  <= set_mins_i;
        end
    end

    assign state_o        = state_q;
    assign snoozes_left_o = snoozes_left_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - directed vector table plus ring/snooze/reset sequences for alarm_ctrl
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [5:0] hours_i = '0, mins_i = '0, secs_i = '0;
    logic       set_en = 1'b0;
    logic [5:0] set_hours_i = '0, set_mins_i = '0;
    logic       alarm_en = 1'b0;
    logic       snooze = 1'b0, stop = 1'b0;
    logic       ringing;
    logic [5:0] alarm_hours_o, alarm_mins_o;
    logic [1:0] state_o;
    logic [2:0] snoozes_left_o;

    int n_vec  = 0;
    int n_fail = 0;

    alarm_ctrl dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .hours_i(hours_i), .mins_i(mins_i), .secs_i(secs_i),
        .set_en(set_en), .set_hours_i(set_hours_i), .set_mins_i(set_mins_i),
        .alarm_en(alarm_en), .snooze(snooze), .stop(stop),
        .ringing(ringing), .alarm_hours_o(alarm_hours_o), .alarm_mins_o(alarm_mins_o),
        .state_o(state_o), .snoozes_left_o(snoozes_left_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       set_en;
        logic [5:0] sh, sm;
        logic       en;
        logic [5:0] h, m, s;
        logic       tick, snz, stp;
        logic [1:0] st;
        logic       rg;
        logic [5:0] ah, am;
        logic [2:0] sl;
        logic       chk_sl;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [1:0] st, input logic rg,
                             input logic [2:0] sl);
        check({name, " state"}, int'(state_o), int'(st));
        check({name, " ringing"}, int'(ringing), int'(rg));
        check({name, " snoozes_left"}, int'(snoozes_left_o), int'(sl));
    endtask

    task automatic do_tick(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        @(negedge clk);
        hours_i = h; mins_i = m; secs_i = s; tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    task automatic do_snooze();
        @(negedge clk);
        snooze = 1'b1;
        @(negedge clk);
        snooze = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //          set sh  sm  en h  m   s   tk sz sp  st   rg ah  am  sl chk
        tbl[0]  = '{0, 0,  0,  0, 0, 0,  0,  0, 0, 0, 2'd0, 0, 0,  0,  0, 1};
        tbl[1]  = '{1, 7,  30, 0, 0, 0,  0,  0, 0, 0, 2'd0, 0, 7,  30, 0, 1};
        tbl[2]  = '{1, 24, 15, 0, 0, 0,  0,  0, 0, 0, 2'd0, 0, 7,  30, 0, 1};
        tbl[3]  = '{1, 5,  60, 0, 0, 0,  0,  0, 0, 0, 2'd0, 0, 7,  30, 0, 1};
        tbl[4]  = '{0, 0,  0,  1, 7, 29, 59, 1, 0, 0, 2'd1, 0, 7,  30, 0, 1};
        tbl[5]  = '{0, 0,  0,  1, 7, 29, 59, 1, 0, 0, 2'd1, 0, 7,  30, 0, 1};
        tbl[6]  = '{0, 0,  0,  1, 7, 30, 0,  0, 0, 0, 2'd1, 0, 7,  30, 0, 1};
        tbl[7]  = '{0, 0,  0,  1, 7, 30, 0,  1, 0, 0, 2'd2, 1, 7,  30, 3, 1};
        tbl[8]  = '{0, 0,  0,  1, 7, 30, 0,  0, 1, 1, 2'd1, 0, 7,  30, 0, 1};
        tbl[9]  = '{0, 0,  0,  1, 7, 30, 1,  1, 0, 0, 2'd1, 0, 7,  30, 0, 1};
        tbl[10] = '{0, 0,  0,  1, 7, 31, 0,  1, 0, 0, 2'd1, 0, 7,  30, 0, 1};
        tbl[11] = '{1, 7,  31, 1, 7, 31, 0,  0, 0, 0, 2'd1, 0, 7,  31, 0, 1};
        tbl[12] = '{0, 0,  0,  1, 7, 31, 0,  1, 0, 0, 2'd2, 1, 7,  31, 3, 1};
        tbl[13] = '{0, 0,  0,  1, 7, 31, 1,  0, 1, 0, 2'd3, 0, 7,  31, 2, 1};
        tbl[14] = '{0, 0,  0,  1, 7, 31, 1,  0, 1, 0, 2'd3, 0, 7,  31, 2, 1};
        tbl[15] = '{1, 6,  0,  1, 7, 31, 1,  0, 0, 0, 2'd3, 0, 6,  0,  2, 1};
        tbl[16] = '{0, 0,  0,  0, 7, 31, 1,  0, 0, 0, 2'd0, 0, 6,  0,  0, 0};
        tbl[17] = '{0, 0,  0,  1, 7, 31, 1,  0, 0, 0, 2'd1, 0, 6,  0,  0, 0};
        tbl[18] = '{0, 0,  0,  0, 6, 0,  0,  1, 0, 0, 2'd0, 0, 6,  0,  0, 0};

        // Reset state, then the vector table
        repeat (2) @(negedge clk);
        check("reset state", int'(state_o), 0);
        check("reset ringing", int'(ringing), 0);
        reset = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            set_en = tbl[i].set_en; set_hours_i = tbl[i].sh; set_mins_i = tbl[i].sm;
            alarm_en = tbl[i].en; hours_i = tbl[i].h; mins_i = tbl[i].m; secs_i = tbl[i].s;
            tick_1hz = tbl[i].tick; snooze = tbl[i].snz; stop = tbl[i].stp;
            @(negedge clk);
            check($sformatf("vec%0d state", i), int'(state_o), int'(tbl[i].st));
            check($sformatf("vec%0d ringing", i), int'(ringing), int'(tbl[i].rg));
            check($sformatf("vec%0d alarm_hours", i), int'(alarm_hours_o), int'(tbl[i].ah));
            check($sformatf("vec%0d alarm_mins", i), int'(alarm_mins_o), int'(tbl[i].am));
            if (tbl[i].chk_sl)
                check($sformatf("vec%0d snoozes_left", i), int'(snoozes_left_o), int'(tbl[i].sl));
        end
        set_en = 1'b0; tick_1hz = 1'b0; snooze = 1'b0; stop = 1'b0;

        // Auto-silence after 60 ticks, no re-ring at 07:31:00
        @(negedge clk);
        set_en = 1'b1; set_hours_i = 6'd7; set_mins_i = 6'd30; alarm_en = 1'b1;
        @(negedge clk);
        set_en = 1'b0;
        check("rearm state", int'(state_o), 1);
        do_tick(6'd7, 6'd30, 6'd0);
        check_all("ring start", 2'd2, 1'b1, 3'd3);
        for (int k = 0; k < 59; k++) do_tick(6'd7, 6'd30, 6'(k + 1));
        check_all("ring 59 ticks", 2'd2, 1'b1, 3'd3);
        do_tick(6'd7, 6'd31, 6'd0);
        check_all("ring timeout", 2'd1, 1'b0, 3'd0);
        do_tick(6'd7, 6'd31, 6'd0);
        check_all("no re-ring 07:31", 2'd1, 1'b0, 3'd0);

        // Three full snooze cycles, then the fourth snooze is ignored
        do_tick(6'd7, 6'd30, 6'd0);
        check_all("ring again", 2'd2, 1'b1, 3'd3);
        for (int k = 1; k <= 3; k++) begin
            do_snooze();
            check_all($sformatf("snooze%0d", k), 2'd3, 1'b0, 3'(3 - k));
            for (int t = 0; t < 299; t++) do_tick(6'd7, 6'd31, 6'd1);
            check($sformatf("snooze%0d 299 ticks state", k), int'(state_o), 3);
            do_tick(6'd7, 6'd31, 6'd1);
            check_all($sformatf("snooze%0d expire", k), 2'd2, 1'b1, 3'(3 - k));
        end
        do_snooze();
        check_all("4th snooze ignored", 2'd2, 1'b1, 3'd0);

        // Asynchronous reset while ringing silences before the next edge
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_all("async reset", 2'd0, 1'b0, 3'd0);
        check("async reset alarm_hours", int'(alarm_hours_o), 0);
        check("async reset alarm_mins", int'(alarm_mins_o), 0);
        @(negedge clk);
        reset = 1'b1;
        #1 check("post reset still disabled", int'(state_o), 0);
        @(negedge clk);
        check("post reset armed", int'(state_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter SNOOZE_SECS, default 300, snooze interval in 1 Hz ticks (1..511).
REQ-002 Parameter RING_SECS, default 60, auto-silence timeout in 1 Hz ticks (1..511).
REQ-003 Parameter MAX_SNOOZES, default 3, snoozes allowed per alarm event (0..7).
REQ-004 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 tick_1hz  input  1  one-clk-wide enable pulse once per second, synchronous to clk.
REQ-007 hours_i  input  6  current time hours, 24 h binary (0..23), from the running clock.
REQ-008 mins_i  input  6  current time minutes (0..59).
REQ-009 secs_i  input  6  current time seconds (0..59).
REQ-010 set_en  input  1  level; load alarm time from set_hours_i/set_mins_i.
REQ-011 set_hours_i  input  6  requested alarm hours.
REQ-012 set_mins_i  input  6  requested alarm minutes.
REQ-013 alarm_en  input  1  level; arm alarm when high.
REQ-014 snooze  input  1  debounced single-clk pulse.
REQ-015 stop  input  1  debounced single-clk pulse.
REQ-016 ringing  output  1  high while alarm sounds.
REQ-017 alarm_hours_o  output  6  stored alarm hours.
REQ-018 alarm_mins_o  output  6  stored alarm minutes.
REQ-019 state_o  output  2  FSM state: 00 DISABLED, 01 ARMED, 10 RINGING, 11 SNOOZED.
REQ-020 snoozes_left_o  output  3  snoozes remaining in current event.

Function
REQ-021 Alarm registers SHALL load on any clk with set_en=1 only if set_hours_i<=23 and set_mins_i<=59; invalid values SHALL leave registers unchanged.
REQ-022 alarm_en=0 SHALL force DISABLED on the next clk edge from any state, with ringing=0; this takes priority over all other events.
REQ-023 DISABLED -> ARMED on the first clk with alarm_en=1.
REQ-024 Match SHALL be: tick_1hz=1 and hours_i==alarm_hours and mins_i==alarm_mins and secs_i==0; only ARMED evaluates match.
REQ-025 ARMED + match -> RINGING on that edge; ring counter loads 0; snoozes_left loads MAX_SNOOZES.
REQ-026 ringing SHALL be a registered output equal to 1 exactly when state is RINGING (asserted the cycle after the matching edge).
REQ-027 In RINGING, event priority: stop > snooze > timeout.
REQ-028 RINGING + stop -> ARMED; snoozes_left -> 0.
REQ-029 RINGING + snooze with snoozes_left>0 -> SNOOZED; snoozes_left decrements by 1; snooze counter loads 0.
REQ-030 RINGING + snooze with snoozes_left=0 SHALL be ignored (keeps ringing).
REQ-031 In RINGING, each tick_1hz increments ring counter; when it would reach RING_SECS -> ARMED, snoozes_left -> 0.
REQ-032 In SNOOZED, each tick_1hz increments snooze counter; when it would reach SNOOZE_SECS -> RINGING, ring counter loads 0.
REQ-033 SNOOZED + stop -> ARMED; snooze input ignored in SNOOZED.
REQ-034 Alarm time writes during RINGING/SNOOZED SHALL update registers without changing state.
REQ-035 Same-second re-match SHALL NOT occur after stop (match requires secs_i==0 at a tick edge, evaluated only in ARMED).
REQ-036 Counters SHALL be 9 bits, never wrap; snoozes_left saturates at 0.

Reset
REQ-037 On reset=0, asynchronously: state DISABLED, ringing=0, alarm_hours_o=0, alarm_mins_o=0, snoozes_left_o=0, counters 0.
REQ-038 Reset asserted mid-RINGING or mid-SNOOZED SHALL silence immediately, without waiting for clk.
REQ-039 After reset release, the FSM SHALL leave DISABLED only per REQ-023.

Verification
REQ-040 Set 07:30, alarm_en=1; drive 07:29:59 tick then 07:30:00 tick -> state_o=10, ringing=1 the next cycle.
REQ-041 Ringing, no input, 60 ticks -> state_o=01, ringing=0; at 07:31:00 no re-ring.
REQ-042 Ringing, snooze pulse -> state_o=11, snoozes_left_o=2; after 300 ticks -> state_o=10; repeat 3x -> 4th snooze ignored, ringing stays 1.
REQ-043 Ringing, snooze and stop in same cycle -> state_o=01 (stop wins).
REQ-044 set_en with set_hours_i=24 -> alarm_hours_o unchanged; alarm_en dropped while SNOOZED -> state_o=00 next edge.
REQ-045 reset=0 asynchronously mid-RINGING -> ringing=0 before the next clk edge; all outputs zero.
